// File: rtl/alu_seq.sv
// Multi-cycle ALU for the KGP_RISC execute stage: one-clock logic/arithmetic ops plus
// bit-serial unsigned multiply and restoring divide behind a start/done handshake.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] ext_out,
    output logic             cFlag,
    output logic             zFlag,
    output logic             sFlag,
    output logic             oFlag,
    output logic             dzFlag
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH:0]   msum, dshift, ddiff;
    logic             launch;

    logic [SHW-1:0]          sh_amt;
    logic [WIDTH:0]          add_w, sub_w, shl_w, shr_w;
    logic signed [WIDTH:0]   sra_w;
    logic [WIDTH-1:0]        sc_out;
    logic                    sc_c, sc_o, sc_z, sc_s;

    assign sh_amt = inp2[SHW-1:0];
    assign launch = (state == S_IDLE) && start &&
                    ((op == OP_MULU) || ((op == OP_DIVU) && (inp2 != '0)));

    // One iteration: hi_reg holds partial product high word / partial remainder,
    // lo_reg shifts out multiplier bits / dividend bits and shifts in quotient bits.
    always_comb begin
        msum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        dshift = {hi_reg, lo_reg[WIDTH-1]};
        ddiff  = dshift - {1'b0, b_reg};
        if (state == S_DIV) begin
            if (!ddiff[WIDTH]) begin
                hi_nxt = ddiff[WIDTH-1:0];
                lo_nxt = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = dshift[WIDTH-1:0];
                lo_nxt = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = msum[WIDTH:1];
            lo_nxt = {msum[0], lo_reg[WIDTH-1:1]};
        end
    end

    // Shifts carry an extra guard bit so the last bit shifted out lands in a fixed position.
    always_comb begin
        add_w  = {1'b0, inp1} + {1'b0, inp2};
        sub_w  = {1'b0, inp1} + {1'b0, ~inp2} + ONE_W;
        shl_w  = {1'b0, inp1} << sh_amt;
        shr_w  = {inp1, 1'b0} >> sh_amt;
        sra_w  = $signed({inp1, 1'b0}) >>> sh_amt;
        sc_out = '0;
        sc_c   = 1'b0;
        sc_o   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_out = add_w[WIDTH-1:0];
                sc_c   = add_w[WIDTH];
                sc_o   = (inp1[WIDTH-1] == inp2[WIDTH-1]) && (add_w[WIDTH-1] != inp1[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                if (op == OP_SUB) sc_out = sub_w[WIDTH-1:0];
                sc_c = sub_w[WIDTH];
                sc_o = (inp1[WIDTH-1] != inp2[WIDTH-1]) && (sub_w[WIDTH-1] != inp1[WIDTH-1]);
            end
            OP_AND: sc_out = inp1 & inp2;
            OP_OR:  sc_out = inp1 | inp2;
            OP_XOR: sc_out = inp1 ^ inp2;
            OP_NOT: sc_out = ~inp1;
            OP_SHL: begin
                sc_out = shl_w[WIDTH-1:0];
                sc_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                sc_out = shr_w[WIDTH:1];
                sc_c   = shr_w[0];
            end
            OP_SRA: begin
                sc_out = sra_w[WIDTH:1];
                sc_c   = sra_w[0];
            end
            default: ;
        endcase
        sc_z = (sc_out == '0);
        sc_s = sc_out[WIDTH-1];
        if (op == OP_CMP) begin
            sc_z = (sub_w[WIDTH-1:0] == '0);
            sc_s = sub_w[WIDTH-1];
        end else if (op > OP_DIVU) begin
            sc_z = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            hi_reg <= '0;
            lo_reg <= inp1;
            b_reg  <= inp2;
        end else if (state != S_IDLE) begin
            hi_reg <= hi_nxt;
            lo_reg <= lo_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
            ext_out <= '0;
            cFlag   <= 1'b0;
            zFlag   <= 1'b0;
            sFlag   <= 1'b0;
            oFlag   <= 1'b0;
            dzFlag  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state <= (op == OP_MULU) ? S_MUL : S_DIV;
                        busy  <= 1'b1;
                        count <= SHW'(WIDTH - 1);
                    end else if (start && (op == OP_DIVU)) begin
                        out     <= '1;
                        ext_out <= inp1;
                        cFlag   <= 1'b0;
                        zFlag   <= 1'b0;
                        sFlag   <= 1'b1;
                        oFlag   <= 1'b0;
                        dzFlag  <= 1'b1;
                        done    <= 1'b1;
                    end else if (start) begin
                        out     <= sc_out;
                        ext_out <= '0;
                        cFlag   <= sc_c;
                        zFlag   <= sc_z;
                        sFlag   <= sc_s;
                        oFlag   <= sc_o;
                        dzFlag  <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    if (count == '0) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        out     <= lo_nxt;
                        ext_out <= hi_nxt;
                        cFlag   <= 1'b0;
                        zFlag   <= (state == S_MUL) ? ({hi_nxt, lo_nxt} == '0) : (lo_nxt == '0);
                        sFlag   <= lo_nxt[WIDTH-1];
                        oFlag   <= 1'b0;
                        dzFlag  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the KGP_RISC datapath. It replaces the purely combinational ALU with a start/done handshake block. Single-cycle logic and arithmetic ops complete in one clock. Unsigned multiply and divide iterate one bit per clock, and their high word or remainder goes to `ext_out`. The execute stage launches one op at a time and stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width; power of two, 8 or more.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: launch request; sampled only while `busy`=0.
- `op` in 4: operation code, sampled with `start`.
- `inp1` in WIDTH: operand A, sampled with `start`.
- `inp2` in WIDTH: operand B or shift amount (`inp2[SHW-1:0]`), sampled with `start`.
- `busy` out 1: iterative op in progress.
- `done` out 1: one-cycle pulse; results valid from this cycle.
- `out` out WIDTH: primary result (sum, logic, shift, product low word, quotient).
- `ext_out` out WIDTH: product high word or remainder; 0 for other ops.
- `cFlag`, `zFlag`, `sFlag`, `oFlag` out 1 each: carry, zero, sign, overflow.
- `dzFlag` out 1: divide-by-zero on the last DIVU.

## Operation
- Op codes:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL logical
  - 7 SHR logical
  - 8 SRA
  - 9 CMP: SUB flags only, `out`/`ext_out` forced 0
  - 10 MULU
  - 11 DIVU
  - 12–15 illegal: treated as single-cycle, all results and flags 0.
- FSM states:
  - IDLE: `start` with op≤9 or illegal → result registers loaded, `done`=1, remain IDLE. `start` with MULU → MUL. `start` with DIVU and B≠0 → DIV.
  - MUL: shift-add, one multiplier bit per cycle; `count` WIDTH−1 down to 0. After the last iteration → IDLE, `done`=1.
  - DIV: restoring division, one quotient bit per cycle; exits like MUL.
- DIVU by zero is single-cycle: `out`=all ones, `ext_out`=A, `dzFlag`=1. Any other completion clears `dzFlag`.
- Operands are latched into internal registers at launch. `inp1`/`inp2`/`op` may change freely while `busy`=1.
- Flags:
  - `cFlag`: ADD = carry-out. SUB/CMP = carry-out of A+~B+1 (1 means no borrow). Shifts = last bit shifted out, 0 when amount is 0. Other ops 0.
  - `oFlag`: signed overflow for ADD/SUB/CMP; 0 otherwise.
  - `zFlag`: (`out`==0) for single-cycle ops; ({`ext_out`,`out`}==0) for MULU; (quotient==0) for DIVU.
  - `sFlag`: MSB of the SUB result for CMP; `out[WIDTH-1]` for all other ops.
- `out`, `ext_out` and all flags hold their last values until the next completion; they change only in the `done` cycle.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `count`=0, `busy`=0, `done`=0, `out`=0, `ext_out`=0, all flags 0. This applies mid-operation: any partial MUL/DIV is discarded and no `done` is issued.
- Single-cycle op (including DIVU by zero): `start` sampled at edge k → results and `done`=1 after edge k. Latency 1; back-to-back `start` every cycle is allowed.
- MULU/DIVU: `start` at edge k → `busy`=1 after edge k. Iterations occur on edges k+1..k+WIDTH. After edge k+WIDTH: `busy`=0, `done`=1, results valid. Latency WIDTH+1.
- `start` while `busy`=1 is ignored, not queued.
- A new `start` is accepted in the `done` cycle: `busy`=0 there, so there is no bubble.
- `done` is high for exactly one cycle per accepted `start`.

## Test plan
- Reset mid-MULU: with WIDTH=32, MULU launched and `rst_n` pulled low after 10 cycles → all outputs 0 immediately; no `done` after release.
- Single-cycle ops: ADD 0x7FFFFFFF+1 → `out`=0x80000000, `oFlag`=1, `sFlag`=1, `cFlag`=0. SUB 2−3 → 0xFFFFFFFF, `cFlag`=0. SRA 0xFFFFFC00 by 3 → 0xFFFFFF80. Each gives `done` one cycle after `start`.
- MULU 0xFFFFFFFF×0xFFFFFFFF → `ext_out`=0xFFFFFFFE, `out`=0x00000001, `done` exactly 33 cycles after `start`, `busy` high for 32 cycles.
- DIVU 1024÷3 → `out`=341, `ext_out`=1, 33-cycle latency. DIVU 5÷0 → `out`=0xFFFFFFFF, `ext_out`=5, `dzFlag`=1, latency 1.
- `start` pulsed with ADD while a DIVU is busy → ignored; only the DIVU `done` occurs. A `start` in that `done` cycle is accepted.
- Parameter sweep: WIDTH=8, MULU 200×200 → {`ext_out`,`out`}=0x9C40, `done` 9 cycles after `start`. SHL 1 by `inp2`=9 → amount 1 (low 3 bits), `out`=2.
